// File: rtl/bus_arbiter4.sv
// bus_arbiter4: four-way round-robin bus arbiter with hold timeout and turnaround gap.
// Define ARB_LOCK_EN to add a lock input that suppresses preemption of the current owner.
module bus_arbiter4 #(
   parameter int HOLD_MAX    = 16,
   parameter int TURN_CYCLES = 1
) (
   input  logic       clk,
   input  logic       reset,
`ifdef ARB_LOCK_EN
   input  logic       lock,
`endif
   input  logic [3:0] req,
   output logic       selA,
   output logic       selB,
   output logic       nOE,
   output logic [3:0] nGnt,
   output logic       busy
);
   localparam int HW = (HOLD_MAX > 0) ? $clog2(HOLD_MAX + 1) : 1;
   localparam int TW = (TURN_CYCLES > 0) ? $clog2(TURN_CYCLES + 1) : 1;
   localparam logic [HW-1:0] HOLD_SAT  = HW'(HOLD_MAX);
   localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_MAX - 1);
   localparam logic [TW-1:0] TURN_LAST = TW'(TURN_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, GRANT, TURN} state_t;

   state_t        state_q, state_d;
   logic [1:0]    last_q, last_d, sel_q, sel_d, pick;
   logic [HW-1:0] hold_q, hold_d;
   logic [TW-1:0] turn_q, turn_d;
   logic          noe_q, noe_d, busy_q, busy_d;
   logic [3:0]    ngnt_q, ngnt_d;
   logic          any_req, others, lock_w, preempt, release_w;

`ifdef ARB_LOCK_EN
   assign lock_w = lock;
`else
   assign lock_w = 1'b0;
`endif

   assign any_req   = |req;
   assign others    = |(req & ~(4'b0001 << sel_q));
   // >= also catches a saturated counter, so a late competitor preempts at once
   assign preempt   = (HOLD_MAX != 0) && (hold_q >= HOLD_LAST) && others && !lock_w;
   assign release_w = !req[sel_q] || preempt;

   // Descending scan so the nearest requester after lastIdx wins
   always_comb begin
      pick = last_q;
      for (int k = 4; k >= 1; k--)
         if (req[last_q + 2'(k)]) pick = last_q + 2'(k);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         last_q  <= 2'd3;
         hold_q  <= '0;
         turn_q  <= '0;
         sel_q   <= 2'd0;
         noe_q   <= 1'b1;
         ngnt_q  <= 4'hF;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         hold_q  <= hold_d;
         turn_q  <= turn_d;
         sel_q   <= sel_d;
         noe_q   <= noe_d;
         ngnt_q  <= ngnt_d;
         busy_q  <= busy_d;
      end
   end

   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      hold_d  = hold_q;
      turn_d  = turn_q;
      sel_d   = sel_q;
      case (state_q)
         IDLE: if (any_req) begin
            state_d = GRANT;
            sel_d   = pick;
            hold_d  = '0;
         end
         GRANT: if (release_w) begin
            state_d = (TURN_CYCLES > 0) ? TURN : IDLE;
            last_d  = sel_q;
            turn_d  = '0;
         end else begin
            hold_d  = (hold_q == HOLD_SAT) ? hold_q : hold_q + 1'b1;
         end
         TURN: if (turn_q == TURN_LAST) begin
            state_d = any_req ? GRANT : IDLE;
            sel_d   = any_req ? pick : sel_q;
            hold_d  = '0;
         end else begin
            turn_d  = turn_q + 1'b1;
         end
         default: state_d = IDLE;
      endcase
   end

   // Outputs are derived from the next state so every port comes straight from a flop
   always_comb begin
      noe_d  = state_d != GRANT;
      busy_d = state_d != IDLE;
      ngnt_d = noe_d ? 4'hF : ~(4'b0001 << sel_d);
   end

   assign {selB, selA} = sel_q;
   assign nOE          = noe_q;
   assign nGnt         = ngnt_q;
   assign busy         = busy_q;
endmodule

// File: tb/tb_bus_arbiter4.sv
// tb_bus_arbiter4: directed scoreboard bench for two arbiter instances (turnaround 1 and 0)
// plus a long random run checking the decoder/grant invariant.
module tb_bus_arbiter4;
   logic       clk = 1'b0, reset = 1'b1;
   logic [3:0] req_a = 4'h0, req_b = 4'h0;
   logic       selA_a, selB_a, nOE_a, busy_a, selA_b, selB_b, nOE_b, busy_b;
   logic [3:0] nGnt_a, nGnt_b;
`ifdef ARB_LOCK_EN
   logic       lock = 1'b0;
`endif

   typedef struct {
      int         d;
      logic [3:0] g;
      logic [1:0] s;
      logic       n;
      logic       b;
      string      tag;
   } exp_t;

   exp_t       sb[$];
   int         errors = 0, checks = 0;
   logic [1:0] esel[2];
   logic [1:0] prev_sel[2];
   logic       prev_noe[2];

   always #5 clk = ~clk;

   bus_arbiter4 #(.HOLD_MAX(4), .TURN_CYCLES(1)) u_a (
      .clk(clk), .reset(reset),
`ifdef ARB_LOCK_EN
      .lock(lock),
`endif
      .req(req_a), .selA(selA_a), .selB(selB_a), .nOE(nOE_a), .nGnt(nGnt_a), .busy(busy_a)
   );

   bus_arbiter4 #(.HOLD_MAX(4), .TURN_CYCLES(0)) u_b (
      .clk(clk), .reset(reset),
`ifdef ARB_LOCK_EN
      .lock(lock),
`endif
      .req(req_b), .selA(selA_b), .selB(selB_b), .nOE(nOE_b), .nGnt(nGnt_b), .busy(busy_b)
   );

   function automatic logic [7:0] obs(input int d);
      return d ? {nGnt_b, selB_b, selA_b, nOE_b, busy_b} : {nGnt_a, selB_a, selA_a, nOE_a, busy_a};
   endfunction

   function automatic logic [1:0] idx_of(input logic [3:0] g);
      for (int i = 0; i < 4; i++)
         if (!g[i]) return 2'(i);
      return 2'd0;
   endfunction

   task automatic check(input string tag, input logic [7:0] o, input logic [7:0] e);
      checks++;
      assert (o === e) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, o, e);
      end
   endtask

   task automatic pop_check();
      exp_t e;
      e = sb.pop_front();
      check(e.tag, obs(e.d), {e.g, e.s, e.n, e.b});
   endtask

   task automatic step(input int d, input logic [3:0] r, input logic [3:0] g, input logic b,
                       input string tag);
      if (d == 0) req_a = r; else req_b = r;
      if (g != 4'hF) esel[d] = idx_of(g);
      sb.push_back('{d, g, esel[d], g == 4'hF, b, tag});
      @(posedge clk);
      #1;
      pop_check();
   endtask

   task automatic rst_step(input string tag);
      reset = 1'b1;
      req_a = 4'hF;
      req_b = 4'hF;
      for (int d = 0; d < 2; d++) begin
         esel[d] = 2'd0;
         sb.push_back('{d, 4'hF, 2'd0, 1'b1, 1'b0, tag});
      end
      @(posedge clk);
      #1;
      pop_check();
      pop_check();
   endtask

   task automatic inv_check(input int d);
      logic [7:0] o;
      logic [3:0] dec;
      o   = obs(d);
      dec = o[1] ? 4'hF : ~(4'b0001 << o[3:2]);
      check(d ? "invariant b" : "invariant a", {4'h0, o[7:4]}, {4'h0, dec});
      if (!prev_noe[d] && !o[1]) check(d ? "no handover b" : "no handover a", {6'h0, o[3:2]}, {6'h0, prev_sel[d]});
      prev_noe[d] = o[1];
      prev_sel[d] = o[3:2];
   endtask

   initial begin
      int ord[5] = '{0, 1, 2, 3, 0};
      logic [3:0] g;
      esel = '{2'd0, 2'd0};
      repeat (3) rst_step("reset");
      reset = 1'b0;
      req_b = 4'h0;
      for (int n = 0; n < 5; n++) begin
         g = ~(4'b0001 << ord[n]);
         repeat (4) step(0, 4'hF, g, 1'b1, "rr grant");
         if (n < 4) step(0, 4'hF, 4'hF, 1'b1, "rr gap");
      end
      step(0, 4'h0, 4'hF, 1'b1, "rr release");
      step(0, 4'h0, 4'hF, 1'b0, "rr idle");
      repeat (5) step(0, 4'b0100, 4'b1011, 1'b1, "single grant");
      step(0, 4'h0, 4'hF, 1'b1, "single release");
      step(0, 4'h0, 4'hF, 1'b0, "single idle");
      repeat (20) step(0, 4'b0010, 4'b1101, 1'b1, "no competitor hold");
      step(0, 4'b0011, 4'hF, 1'b1, "late preempt");
      step(0, 4'b0011, 4'b1110, 1'b1, "req0 after turn");
      step(0, 4'h0, 4'hF, 1'b1, "late release");
      step(0, 4'h0, 4'hF, 1'b0, "late idle");
      step(0, 4'b0100, 4'b1011, 1'b1, "pre-reset grant");
      rst_step("reset mid grant");
      reset = 1'b0;
      req_b = 4'h0;
`ifdef ARB_LOCK_EN
      lock = 1'b1;
      repeat (10) step(0, 4'b0011, 4'b1110, 1'b1, "lock hold");
      step(0, 4'b0010, 4'hF, 1'b1, "lock release");
      step(0, 4'b0010, 4'b1101, 1'b1, "lock next");
      lock = 1'b0;
      step(0, 4'h0, 4'hF, 1'b1, "lock drop");
      step(0, 4'h0, 4'hF, 1'b0, "lock idle");
`endif
      repeat (4) step(0, 4'b0011, 4'b1110, 1'b1, "preempt hold");
      step(0, 4'b0011, 4'hF, 1'b1, "preempt gap");
      step(0, 4'b0011, 4'b1101, 1'b1, "preempt next");
      step(0, 4'h0, 4'hF, 1'b1, "preempt release");
      step(0, 4'h0, 4'hF, 1'b0, "preempt idle");
      repeat (2) step(1, 4'b0001, 4'b1110, 1'b1, "t0 grant");
      step(1, 4'b1000, 4'hF, 1'b0, "t0 gap");
      step(1, 4'b1000, 4'b0111, 1'b1, "t0 next");
      step(1, 4'h0, 4'hF, 1'b0, "t0 release");
      repeat (4) step(1, 4'b0011, 4'b1110, 1'b1, "t0 preempt hold");
      step(1, 4'b0011, 4'hF, 1'b0, "t0 preempt gap");
      step(1, 4'b0011, 4'b1101, 1'b1, "t0 preempt next");
      step(1, 4'h0, 4'hF, 1'b0, "t0 preempt release");
      prev_noe = '{1'b1, 1'b1};
      prev_sel = '{2'd0, 2'd0};
      for (int c = 0; c < 10000; c++) begin
         if ($urandom_range(0, 7) == 0) req_a = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 7) == 0) req_b = 4'($urandom_range(0, 15));
`ifdef ARB_LOCK_EN
         if ($urandom_range(0, 15) == 0) lock = 1'($urandom_range(0, 1));
`endif
         @(posedge clk);
         #1;
         inv_check(0);
         inv_check(1);
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
